// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port column-write block RAM family.
// The clear-state enum is only used when BRAM_CLEAR_ON_RESET_EN is defined.
package bram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Widest word / column count the merge helper supports.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_COL    = 128;

    function automatic bit rd_latency_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    // Columns set in col_mask take new_word, all others keep old_word.
    function automatic logic [MAX_DATA_W-1:0] col_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_COL-1:0]    col_mask,
        input int                    col_width
    );
        logic [MAX_DATA_W-1:0] bit_mask;
        logic [MAX_DATA_W-1:0] col_ones;
        bit_mask = '0;
        col_ones = (MAX_DATA_W'(1) << col_width) - MAX_DATA_W'(1);
        for (int c = 0; c < MAX_COL; c++) begin
            if (|(col_mask & (MAX_COL'(1) << c))) begin
                bit_mask = bit_mask | (col_ones << (c * col_width));
            end
        end
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port output stage: carries read data, valid and a collision tag through
// RD_LATENCY registers. Data only moves on valid so dout holds between reads.
module bram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_coll,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_coll
);

    genvar gi;
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_valid;
        logic                  r_coll;
        logic [DATA_WIDTH-1:0] w_data_in;
        logic                  w_valid_in;
        logic                  w_coll_in;

        if (gi == 0) begin : g_head
            assign w_data_in  = i_data;
            assign w_valid_in = i_valid;
            assign w_coll_in  = i_coll;
        end else begin : g_tail
            assign w_data_in  = g_stage[gi-1].r_data;
            assign w_valid_in = g_stage[gi-1].r_valid;
            assign w_coll_in  = g_stage[gi-1].r_coll;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_coll  <= 1'b0;
            end else begin
                r_valid <= w_valid_in;
                r_coll  <= w_valid_in & w_coll_in;
                if (w_valid_in) begin
                    r_data <= w_data_in;
                end
            end
        end
    end

    assign o_data  = g_stage[RD_LATENCY-1].r_data;
    assign o_valid = g_stage[RD_LATENCY-1].r_valid;
    assign o_coll  = g_stage[RD_LATENCY-1].r_coll;

endmodule

// File: rtl/bram_tdp_colwe_fwd.sv
// True dual-port column-write RAM with write-first forwarding across ports,
// A-wins collision ordering and optional post-reset clear (BRAM_CLEAR_ON_RESET_EN).
module bram_tdp_colwe_fwd
    import bram_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  enaA,
    input  logic                  enaB,
    input  logic [NUM_COL-1:0]    weA,
    input  logic [NUM_COL-1:0]    weB,
    input  logic [ADDR_WIDTH-1:0] addrA,
    input  logic [ADDR_WIDTH-1:0] addrB,
    input  logic [DATA_WIDTH-1:0] dinA,
    input  logic [DATA_WIDTH-1:0] dinB,
    output logic [DATA_WIDTH-1:0] doutA,
    output logic [DATA_WIDTH-1:0] doutB,
    output logic                  validA,
    output logic                  validB,
    output logic                  collision
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("bram_tdp_colwe_fwd: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH != NUM_COL * COL_WIDTH || DATA_WIDTH > MAX_DATA_W || NUM_COL > MAX_COL) begin : g_bad_width
        $error("bram_tdp_colwe_fwd: DATA_WIDTH must equal NUM_COL*COL_WIDTH and fit the merge helper");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_ready;
    logic                  w_issue_a;
    logic                  w_issue_b;
    logic [NUM_COL-1:0]    w_wmask_a;
    logic [NUM_COL-1:0]    w_wmask_b;
    logic                  w_coll;
    logic                  w_coll_a;
    logic                  w_coll_b;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic [ADDR_WIDTH-1:0] w_addr [2];
    logic [DATA_WIDTH-1:0] w_fwd  [2];

    assign ready     = r_ready;
    assign w_issue_a = r_ready & enaA;
    assign w_issue_b = r_ready & enaB;
    assign w_wmask_a = {NUM_COL{w_issue_a}} & weA;
    assign w_wmask_b = {NUM_COL{w_issue_b}} & weB;
    assign w_coll    = w_issue_a & w_issue_b & (addrA == addrB) & (|(weA & weB));
    assign w_addr[0] = addrA;
    assign w_addr[1] = addrB;

    // Each port sees the word after B's and then A's column writes this cycle.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_fwd
        logic [DATA_WIDTH-1:0] w_old;
        logic [DATA_WIDTH-1:0] w_post_b;
        assign w_old    = r_mem[w_addr[gi]];
        assign w_post_b = (addrB == w_addr[gi])
                        ? DATA_WIDTH'(col_merge(MAX_DATA_W'(w_old), MAX_DATA_W'(dinB),
                                                MAX_COL'(w_wmask_b), COL_WIDTH))
                        : w_old;
        assign w_fwd[gi] = (addrA == w_addr[gi])
                         ? DATA_WIDTH'(col_merge(MAX_DATA_W'(w_post_b), MAX_DATA_W'(dinA),
                                                 MAX_COL'(w_wmask_a), COL_WIDTH))
                         : w_post_b;
    end

    // Later non-blocking writes win, so A's columns override B's on a shared address.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end
        for (int c = 0; c < NUM_COL; c++) begin
            if (w_wmask_b[c]) begin
                r_mem[addrB][c*COL_WIDTH +: COL_WIDTH] <= dinB[c*COL_WIDTH +: COL_WIDTH];
            end
        end
        for (int c = 0; c < NUM_COL; c++) begin
            if (w_wmask_a[c]) begin
                r_mem[addrA][c*COL_WIDTH +: COL_WIDTH] <= dinA[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

`ifdef BRAM_CLEAR_ON_RESET_EN
    clr_state_t            r_clr_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_state <= CLEAR;
            r_clr_cnt   <= '0;
            r_ready     <= 1'b0;
        end else if (r_clr_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (&r_clr_cnt) begin
                r_clr_state <= READY;
                r_ready     <= 1'b1;
            end
        end
    end

    assign w_clr_we   = (r_clr_state == CLEAR) && !rst;
    assign w_clr_addr = r_clr_cnt;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    bram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue_a),
        .i_data  (w_fwd[0]),
        .i_coll  (w_coll),
        .o_data  (doutA),
        .o_valid (validA),
        .o_coll  (w_coll_a)
    );

    bram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue_b),
        .i_data  (w_fwd[1]),
        .i_coll  (1'b0),
        .o_data  (doutB),
        .o_valid (validB),
        .o_coll  (w_coll_b)
    );

    assign collision = w_coll_a | w_coll_b;

endmodule

// File: tb/tb_bram_tdp_colwe_fwd.sv
// Directed bench for bram_tdp_colwe_fwd: one RD_LATENCY=1 and one RD_LATENCY=2
// instance share the same stimulus; clear checks depend on BRAM_CLEAR_ON_RESET_EN.
module tb_bram_tdp_colwe_fwd;

    localparam int NC = 4;
    localparam int CW = 2;
    localparam int AW = 4;
    localparam int DW = NC * CW;
`ifdef BRAM_CLEAR_ON_RESET_EN
    localparam int EXP_READY = 16;
`else
    localparam int EXP_READY = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enaA, enaB;
    logic [NC-1:0] weA, weB;
    logic [AW-1:0] addrA, addrB;
    logic [DW-1:0] dinA, dinB;

    logic          ready, validA, validB, collision;
    logic [DW-1:0] doutA, doutB;
    logic          ready2, validA2, validB2, collision2;
    logic [DW-1:0] doutA2, doutB2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    bram_tdp_colwe_fwd #(
        .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW), .RD_LATENCY(1)
    ) u_dut (
        .clk(clk), .rst(rst), .ready(ready),
        .enaA(enaA), .enaB(enaB), .weA(weA), .weB(weB),
        .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
        .doutA(doutA), .doutB(doutB), .validA(validA), .validB(validB),
        .collision(collision)
    );

    bram_tdp_colwe_fwd #(
        .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW), .RD_LATENCY(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .ready(ready2),
        .enaA(enaA), .enaB(enaB), .weA(weA), .weB(weB),
        .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
        .doutA(doutA2), .doutB(doutB2), .validA(validA2), .validB(validB2),
        .collision(collision2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic [NC-1:0] we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
        enaA  = en;
        weA   = we;
        addrA = addr;
        dinA  = din;
    endtask

    task automatic drive_b(input logic en, input logic [NC-1:0] we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
        enaB  = en;
        weB   = we;
        addrB = addr;
        dinB  = din;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int seen_valid;

        rst = 1'b1;
        drive_a(1'b0, '0, '0, '0);
        drive_b(1'b0, '0, '0, '0);
        repeat (3) step();

        chk("rst_ready",     32'(ready),     32'(0));
        chk("rst_doutA",     32'(doutA),     32'(0));
        chk("rst_doutB",     32'(doutB),     32'(0));
        chk("rst_validA",    32'(validA),    32'(0));
        chk("rst_validB",    32'(validB),    32'(0));
        chk("rst_collision", 32'(collision), 32'(0));

        // First release, interrupted by a second reset after 8 cycles.
        rst = 1'b0;
        drive_a(1'b1, '0, 4'd0, '0);
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            step();
`ifdef BRAM_CLEAR_ON_RESET_EN
            if (validA) seen_valid++;
`endif
        end
`ifdef BRAM_CLEAR_ON_RESET_EN
        chk("midclear_ready", 32'(ready), 32'(0));
        chk("midclear_no_valid", 32'(seen_valid), 32'(0));
`else
        chk("noclear_ready", 32'(ready), 32'(1));
`endif
        rst = 1'b1;
        step();
        chk("rst2_ready",  32'(ready),  32'(0));
        chk("rst2_validA", 32'(validA), 32'(0));
        rst = 1'b0;

        cyc = 0;
        seen_valid = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (validA) seen_valid++;
            if (ready) begin
                cyc = n;
                break;
            end
        end
        chk("ready_latency", 32'(cyc), 32'(EXP_READY));
        chk("ready_no_early_access", 32'(seen_valid), 32'(0));
        chk("ready_lat2", 32'(ready2), 32'(1));

`ifdef BRAM_CLEAR_ON_RESET_EN
        for (int a = 0; a < 16; a++) begin
            drive_a(1'b1, '0, AW'(a), '0);
            step();
            chk($sformatf("clear_valid[%0d]", a), 32'(validA), 32'(1));
            chk($sformatf("clear_dout[%0d]", a),  32'(doutA),  32'(0));
        end
`endif

        // Full writes return the written word; read back afterwards.
        drive_a(1'b1, 4'b1111, 4'd1, 8'h5A);
        step();
        chk("wr1_doutA", 32'(doutA), 32'h5A);
        chk("wr1_validA", 32'(validA), 32'(1));
        drive_a(1'b1, 4'b1111, 4'd3, 8'hF0);
        step();
        chk("wr3_doutA", 32'(doutA), 32'hF0);
        drive_a(1'b1, 4'b0000, 4'd1, 8'h00);
        drive_b(1'b1, 4'b0000, 4'd3, 8'h00);
        step();
        chk("rd1_doutA", 32'(doutA), 32'h5A);
        chk("rd3_doutB", 32'(doutB), 32'hF0);
        drive_b(1'b0, '0, '0, '0);

        // Partial write clears columns 0 and 2 of 0xFF.
        drive_a(1'b1, 4'b1111, 4'd2, 8'hFF);
        step();
        chk("pw_full_doutA", 32'(doutA), 32'hFF);
        drive_a(1'b1, 4'b0101, 4'd2, 8'h00);
        step();
        chk("pw_merge_doutA", 32'(doutA), 32'hCC);

        // B reads the address A writes in the same cycle.
        drive_a(1'b1, 4'b1111, 4'd5, 8'h3C);
        drive_b(1'b1, 4'b0000, 4'd5, 8'h00);
        step();
        chk("xfwd_doutB", 32'(doutB), 32'h3C);
        chk("xfwd_validB", 32'(validB), 32'(1));
        chk("xfwd_doutA", 32'(doutA), 32'h3C);
        chk("xfwd_collision", 32'(collision), 32'(0));
        drive_b(1'b0, '0, '0, '0);

        // Collision: preload 0x40, then B cols 1,2 = 01, A cols 0,1 = 10 -> 0x5A.
        drive_a(1'b1, 4'b1111, 4'd7, 8'h40);
        step();
        chk("coll_pre_doutA", 32'(doutA), 32'h40);
        drive_a(1'b1, 4'b0011, 4'd7, 8'hAA);
        drive_b(1'b1, 4'b0110, 4'd7, 8'h55);
        step();
        chk("coll_doutA", 32'(doutA), 32'h5A);
        chk("coll_doutB", 32'(doutB), 32'h5A);
        chk("coll_flag", 32'(collision), 32'(1));
        chk("coll_lat2_prev_doutA", 32'(doutA2), 32'h40);
        chk("coll_lat2_flag_early", 32'(collision2), 32'(0));
        drive_a(1'b0, '0, '0, '0);
        drive_b(1'b0, '0, '0, '0);
        step();
        chk("coll_flag_clear", 32'(collision), 32'(0));
        chk("idle_validA", 32'(validA), 32'(0));
        chk("idle_doutA_hold", 32'(doutA), 32'h5A);
        chk("coll_lat2_doutA", 32'(doutA2), 32'h5A);
        chk("coll_lat2_doutB", 32'(doutB2), 32'h5A);
        chk("coll_lat2_validB", 32'(validB2), 32'(1));
        chk("coll_lat2_flag", 32'(collision2), 32'(1));
        chk("coll_lat2_validA", 32'(validA2), 32'(1));
        drive_b(1'b1, 4'b0000, 4'd7, 8'h00);
        step();
        chk("coll_readback_doutB", 32'(doutB), 32'h5A);
        chk("coll_lat2_flag_clear", 32'(collision2), 32'(0));
        drive_b(1'b0, '0, '0, '0);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
